// File: rtl/car_cmd_responder.sv
// UART command receiver and obstacle-report transmitter for a remote car.
// Command frames latch six motion/action bits; periodic frames report the four detector levels.
module car_cmd_responder #(
    parameter int CLK_HZ      = 100000000,
    parameter int BAUD        = 9600,
    parameter int REPORT_CYC  = 1000000,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic rxd,
    output logic txd,
    input  logic obs_front,
    input  logic obs_back,
    input  logic obs_left,
    input  logic obs_right,
    output logic cmd_forward,
    output logic cmd_backward,
    output logic cmd_left,
    output logic cmd_right,
    output logic cmd_place,
    output logic cmd_destroy,
    output logic cmd_valid,
    output logic frame_err
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int RW   = $clog2(REPORT_CYC + 1);
    localparam int WW   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(REPORT_CYC - 1);
    localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

    // ---------------- receive path ----------------
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d;
    logic            rx_ok, rx_err;
    logic            rx_fall;

    // rx_prev_q lets a falling edge arm the receiver only after the line has been seen high.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_ok      = 1'b0;
        rx_err     = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = R_START;
            end
            R_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_sync_q ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = R_IDLE;
                    if (!rx_sync_q || rx_sh_q[7:6] != 2'b10) rx_err = 1'b1;
                    else                                     rx_ok  = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // ---------------- command latch and watchdog ----------------
    logic [5:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, frame_err_q;
    logic [WW-1:0] wd_q, wd_d;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            wd_q        <= '0;
        end else begin
            cmd_q       <= cmd_d;
            cmd_valid_q <= rx_ok;
            frame_err_q <= rx_err;
            wd_q        <= wd_d;
        end
    end

    // Contradictory forward+backward resolves to stop; an expired watchdog keeps motion cleared.
    always_comb begin
        cmd_d = cmd_q;
        wd_d  = wd_q;
        if (rx_ok) begin
            cmd_d = rx_sh_q[5:0];
            if (rx_sh_q[0] && rx_sh_q[1]) cmd_d[1:0] = 2'b00;
            wd_d = '0;
        end else if (wd_q == WD_MAX) begin
            cmd_d[3:0] = 4'b0000;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    assign cmd_forward  = cmd_q[0];
    assign cmd_backward = cmd_q[1];
    assign cmd_left     = cmd_q[2];
    assign cmd_right    = cmd_q[3];
    assign cmd_place    = cmd_q[4];
    assign cmd_destroy  = cmd_q[5];
    assign cmd_valid    = cmd_valid_q;
    assign frame_err    = frame_err_q;

    // ---------------- report timer and transmit path ----------------
    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_wrap;
    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          txd_q, txd_d;

    assign rpt_wrap = (rpt_q == RPT_LAST);
    assign rpt_d    = rpt_wrap ? '0 : rpt_q + 1'b1;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q      <= '0;
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            txd_q      <= 1'b1;
        end else begin
            rpt_q      <= rpt_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            txd_q      <= txd_d;
        end
    end

    // txd_d tracks the level of the bit being entered so txd_q changes on the same edge as the state.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        case (tx_state_q)
            T_IDLE: begin
                txd_d    = 1'b1;
                tx_cnt_d = '0;
                if (rpt_wrap) begin
                    tx_sh_d    = {4'b0000, obs_right, obs_left, obs_back, obs_front};
                    tx_state_d = T_START;
                    txd_d      = 1'b0;
                end
            end
            T_START: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = T_DATA;
                    txd_d      = tx_sh_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            T_DATA: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = T_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                        txd_d    = tx_sh_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            T_STOP: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = T_IDLE;
                    txd_d      = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    assign txd = txd_q;

endmodule

// File: tb/tb_car_cmd_responder.sv
// Directed bench for car_cmd_responder: command frames, framing errors, watchdog,
// report frame timing/content and asynchronous reset behaviour.
module tb_car_cmd_responder;

    localparam int DIV = 10;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic rxd     = 1'b1;
    logic txd;
    logic obs_front = 1'b0, obs_back = 1'b0, obs_left = 1'b0, obs_right = 1'b0;
    logic cmd_forward, cmd_backward, cmd_left, cmd_right, cmd_place, cmd_destroy;
    logic cmd_valid, frame_err;
    logic [5:0] cmd;

    int n_vec  = 0;
    int n_miss = 0;
    int n_valid = 0;
    int n_err   = 0;
    logic [0:0] exp_q[$];

    car_cmd_responder #(
        .CLK_HZ(1000), .BAUD(100), .REPORT_CYC(200), .TIMEOUT_CYC(500)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .rxd(rxd), .txd(txd),
        .obs_front(obs_front), .obs_back(obs_back), .obs_left(obs_left), .obs_right(obs_right),
        .cmd_forward(cmd_forward), .cmd_backward(cmd_backward), .cmd_left(cmd_left),
        .cmd_right(cmd_right), .cmd_place(cmd_place), .cmd_destroy(cmd_destroy),
        .cmd_valid(cmd_valid), .frame_err(frame_err)
    );

    assign cmd = {cmd_destroy, cmd_place, cmd_right, cmd_left, cmd_backward, cmd_forward};

    // ---------------- clock ----------------
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // Pulse counters sampled on the falling edge; a one-cycle pulse adds exactly one.
    always @(negedge sys_clk) begin
        if (cmd_valid) n_valid++;
        if (frame_err) n_err++;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic hold(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        hold(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            hold(DIV);
        end
        rxd = stop_bit;
        hold(DIV);
        rxd = 1'b1;
        hold(10);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input logic stop_bit,
                             input int exp_v, input int exp_e, input logic [5:0] exp_cmd);
        int v0, e0;
        v0 = n_valid;
        e0 = n_err;
        send_byte(b, stop_bit);
        check_eq({tag, "_valid"}, n_valid - v0, exp_v);
        check_eq({tag, "_err"},   n_err - e0,   exp_e);
        check_eq({tag, "_cmd"},   {26'd0, cmd}, {26'd0, exp_cmd});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rpt_byte;
        logic [7:0] exp_rpt;
        int v0, e0, lows;

        hold(3);
        check_eq("rst_txd",   txd, 1);
        check_eq("rst_cmd",   cmd, 0);
        check_eq("rst_valid", cmd_valid, 0);
        check_eq("rst_err",   frame_err, 0);

        // Report frame: obs_front and obs_right set -> 8'h09, start bit on the 200th edge.
        obs_front = 1'b1;
        obs_right = 1'b1;
        exp_rpt = 8'h09;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_rpt[i]);
        exp_q.push_back(1'b1);
        rst_n = 1'b1;
        hold(199);
        check_eq("tx_before_start", txd, 1);
        hold(1);
        rpt_byte = '0;
        for (int k = 0; k < 10; k++) begin
            logic [0:0] eb;
            eb = exp_q.pop_front();
            check_eq($sformatf("tx_bit%0d_first", k), txd, eb);
            hold(DIV - 1);
            check_eq($sformatf("tx_bit%0d_last", k), txd, eb);
            if (k >= 1 && k <= 8) rpt_byte[k-1] = txd;
            hold(1);
        end
        check_eq("tx_byte", rpt_byte, 8'h09);

        // Command frames.
        run_frame("f85", 8'h85, 1'b1, 1, 0, 6'b000101);
        run_frame("f43", 8'h43, 1'b1, 0, 1, 6'b000101);
        run_frame("f80_badstop", 8'h80, 1'b0, 0, 1, 6'b000101);
        run_frame("f83", 8'h83, 1'b1, 1, 0, 6'b000000);
        run_frame("f8f", 8'h8F, 1'b1, 1, 0, 6'b001100);

        // Short low glitch on rxd is a false start.
        v0 = n_valid;
        e0 = n_err;
        rxd = 1'b0;
        hold(3);
        rxd = 1'b1;
        hold(30);
        check_eq("glitch_valid", n_valid - v0, 0);
        check_eq("glitch_err",   n_err - e0,   0);
        check_eq("glitch_cmd",   cmd, 6'b001100);

        // Watchdog clears motion bits but keeps place/destroy.
        run_frame("fb1", 8'hB1, 1'b1, 1, 0, 6'b110001);
        hold(430);
        check_eq("wd_before", cmd, 6'b110001);
        hold(80);
        check_eq("wd_after", cmd, 6'b110000);

        // Reset in the middle of a report frame and a partial received byte.
        for (int i = 0; i < 250 && txd; i++) hold(1);
        check_eq("report_seen", txd, 0);
        rxd = 1'b0;
        hold(15);
        rxd = 1'b1;
        hold(10);
        check_eq("txd_pre_reset", txd, 0);
        v0 = n_valid;
        e0 = n_err;
        rst_n = 1'b0;
        #1;
        check_eq("txd_async_reset", txd, 1);
        check_eq("cmd_async_reset", cmd, 0);
        hold(3);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            hold(1);
            if (!txd) lows++;
        end
        check_eq("post_rst_valid", n_valid - v0, 0);
        check_eq("post_rst_err",   n_err - e0,   0);
        check_eq("post_rst_txd_low", lows, 0);
        check_eq("post_rst_cmd", cmd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/car_cmd_responder.md
CAR_CMD_RESPONDER -- requirements
Module: car_cmd_responder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, UART bit rate; DIV = CLK_HZ/BAUD, truncated integer.
REQ-003 SHALL have parameter REPORT_CYC, default 1000000, sys_clk cycles between detector report frames.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50000000, sys_clk cycles without a valid command frame before motion commands clear.
REQ-005 sys_clk  input  1  clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 rxd  input  1  UART serial in (command frames), asynchronous to sys_clk.
REQ-008 txd  output  1  UART serial out (detector report frames).
REQ-009 obs_front, obs_back, obs_left, obs_right  input  1 each  obstacle detector levels.
REQ-010 cmd_forward, cmd_backward, cmd_left, cmd_right, cmd_place, cmd_destroy  output  1 each  latched command bits.
REQ-011 cmd_valid  output  1  one-cycle pulse when a valid command frame is accepted.
REQ-012 frame_err  output  1  one-cycle pulse when a received frame is rejected.

Function
REQ-013 UART format SHALL be 8N1, LSB first, idle high, bit time DIV cycles, both directions.
REQ-014 rxd SHALL pass a 2-flop synchronizer; all RX decisions use the synchronized value.
REQ-015 RX FSM states SHALL be R_IDLE, R_START, R_DATA, R_STOP.
REQ-016 R_IDLE -> R_START on synchronized falling edge; R_START samples at DIV/2 cycles; sample high -> R_IDLE (false start, no error pulse).
REQ-017 R_DATA SHALL sample 8 bits at DIV-cycle spacing from the start-bit centre; R_STOP samples one further DIV later.
REQ-018 Stop bit low -> frame_err pulse, byte discarded, FSM -> R_IDLE, waits for rxd high before re-arming.
REQ-019 Command byte layout: bit0 forward, bit1 backward, bit2 left, bit3 right, bit4 place, bit5 destroy, bits[7:6] header = 2'b10.
REQ-020 Header != 2'b10 SHALL pulse frame_err and leave cmd_* unchanged.
REQ-021 Valid frame SHALL update all six cmd_* on the cycle after the stop sample, with cmd_valid pulsing that same cycle.
REQ-022 forward and backward both set SHALL latch both cmd_forward and cmd_backward as 0; other bits latch as received.
REQ-023 Watchdog counter SHALL reset on each cmd_valid; on reaching TIMEOUT_CYC it SHALL clear cmd_forward, cmd_backward, cmd_left, cmd_right (place/destroy unaffected) and hold until the next valid frame.
REQ-024 Report counter SHALL free-run modulo REPORT_CYC; at wrap, if TX idle, TX starts a frame; if TX busy, that report is skipped.
REQ-025 Report byte SHALL be {4'b0000, obs_right, obs_left, obs_back, obs_front}, captured on the trigger cycle.
REQ-026 TX FSM states SHALL be T_IDLE, T_START, T_DATA, T_STOP, each bit held exactly DIV cycles; txd registered, high in T_IDLE.
REQ-027 RX and TX SHALL operate independently; simultaneous reception and transmission allowed.

Reset
REQ-028 During rst_n low: txd=1, cmd_*=0, cmd_valid=0, frame_err=0, both FSMs idle, all counters 0.
REQ-029 Reset mid-frame SHALL abort both directions; the partial RX byte is discarded, no pulses on release.
REQ-030 After release, first report frame starts REPORT_CYC cycles later.

Verification (CLK_HZ=1000, BAUD=100, DIV=10, REPORT_CYC=200, TIMEOUT_CYC=500)
REQ-031 Send 8'h85 -> cmd_forward=1, cmd_left=1, others 0; cmd_valid one pulse; frame_err stays 0.
REQ-032 Send 8'h43 (header 01), then 8'h80 with stop bit forced low -> two frame_err pulses, cmd_* unchanged.
REQ-033 Send 8'h83 -> cmd_forward=cmd_backward=0, cmd_valid pulses.
REQ-034 obs_front=1, obs_right=1 -> txd frame decodes as 8'h09, start bit at cycle 200 after reset, each bit 10 cycles.
REQ-035 Send 8'hB1, then idle 500 cycles -> forward clears, cmd_place and cmd_destroy remain 1.
REQ-036 rxd low glitch of 3 cycles -> no cmd_valid, no frame_err; rst_n pulse mid-report -> txd=1 immediately.
